// File: rtl/pipeline_control_if.sv
// pipeline_control_if: hazard/memory request inputs and stage enable/flush outputs of the pipeline controller.
interface pipeline_control_if;
    logic        lu_stall_f, lu_stall_d, lu_flush_e;
    logic        redirect_e, imem_ready, dmem_req_m, dmem_ready;
    logic        en_f, en_d, en_e, en_m, en_w;
    logic        flush_d, flush_e, flush_w;
    logic        mem_busy, mem_timeout;
    logic [31:0] stall_cycles, flush_events;
    modport master (
        output lu_stall_f, lu_stall_d, lu_flush_e, redirect_e, imem_ready, dmem_req_m, dmem_ready,
        input  en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_w,
        input  mem_busy, mem_timeout, stall_cycles, flush_events
    );
    modport slave (
        input  lu_stall_f, lu_stall_d, lu_flush_e, redirect_e, imem_ready, dmem_req_m, dmem_ready,
        output en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_w,
        output mem_busy, mem_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_control.sv
// pipeline_control: prioritised stall/flush generation with data-memory wait FSM and timeout.
// Define PIPE_PERF_CNT_EN to build the stall_cycles/flush_events performance counters.
module pipeline_control #(
    parameter int DMEM_TIMEOUT = 255
) (
    input logic clk,
    input logic reset,
    pipeline_control_if.slave bus
);
    localparam int CW = (DMEM_TIMEOUT > 0) ? $clog2(DMEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(DMEM_TIMEOUT);
    typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic memstall, lu_any;
    logic [4:0] en;
    logic [2:0] fl;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // The timeout compares the count including the current WAIT cycle, so ERROR follows exactly DMEM_TIMEOUT waits.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cnt_inc  = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
        memstall = 1'b0;
        case (state_q)
            IDLE: begin
                memstall = bus.dmem_req_m && !bus.dmem_ready;
                if (memstall) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                memstall = !bus.dmem_ready;
                cnt_d    = cnt_inc;
                state_d  = bus.dmem_ready ? IDLE : (cnt_inc == TMO) ? ERROR : WAIT;
            end
            default: memstall = 1'b1;
        endcase
    end
    assign lu_any = bus.lu_stall_f || bus.lu_stall_d || bus.lu_flush_e;
    always_comb begin
        en = 5'b11111;
        fl = 3'b000;
        if (reset) begin
            en = 5'b00000;
            fl = 3'b111;
        end else if (memstall) begin
            en = 5'b00001;
            fl = 3'b001;
        end else if (bus.redirect_e) begin
            fl = 3'b110;
        end else if (lu_any) begin
            en[4] = !bus.lu_stall_f;
            en[3] = !bus.lu_stall_d;
            fl[1] = bus.lu_flush_e;
        end else if (!bus.imem_ready) begin
            en[4] = 1'b0;
            fl[2] = 1'b1;
        end
    end
    assign {bus.en_f, bus.en_d, bus.en_e, bus.en_m, bus.en_w} = en;
    assign {bus.flush_d, bus.flush_e, bus.flush_w} = fl;
    assign bus.mem_busy    = (state_q == WAIT);
    assign bus.mem_timeout = (state_q == ERROR);
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_q + 32'(!en[4]);
            flush_q <= flush_q + 32'(fl[2] || fl[1]);
        end
    end
    assign bus.stall_cycles = stall_q;
    assign bus.flush_events = flush_q;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_events = '0;
`endif
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed scoreboard bench for pipeline_control with DMEM_TIMEOUT=4.
module tb_pipeline_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;
    logic [9:0] exp_q[$];
    string tag_q[$];
    // expected vector: {en_f,en_d,en_e,en_m,en_w, flush_d,flush_e,flush_w, mem_busy, mem_timeout}
    localparam logic [9:0] RUN  = 10'b11111_000_0_0;
    localparam logic [9:0] RST  = 10'b00000_111_0_0;
    localparam logic [9:0] MS   = 10'b00001_001_0_0;
    localparam logic [9:0] MSB  = 10'b00001_001_1_0;
    localparam logic [9:0] ERR  = 10'b00001_001_0_1;
    localparam logic [9:0] RDR  = 10'b11111_110_0_0;
    localparam logic [9:0] LU   = 10'b00111_010_0_0;
    localparam logic [9:0] IMS  = 10'b01111_100_0_0;
    pipeline_control_if b();
    pipeline_control #(.DMEM_TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(b));
    always #5 clk = ~clk;
    task automatic check_out();
        logic [9:0] e, obs;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        obs = {b.en_f, b.en_d, b.en_e, b.en_m, b.en_w, b.flush_d, b.flush_e, b.flush_w, b.mem_busy, b.mem_timeout};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s outputs got %b want %b", t, obs, e);
        end
        checks++;
        assert (b.stall_cycles === m_stall) else begin
            errors++;
            $error("FAIL %s stall_cycles got %0d want %0d", t, b.stall_cycles, m_stall);
        end
        checks++;
        assert (b.flush_events === m_flush) else begin
            errors++;
            $error("FAIL %s flush_events got %0d want %0d", t, b.flush_events, m_flush);
        end
`ifdef PIPE_PERF_CNT_EN
        if (!reset) begin
            if (!e[9]) m_stall++;
            if (e[4] || e[3]) m_flush++;
        end
`endif
    endtask
    // in = {reset, lu_stall_f, lu_stall_d, lu_flush_e, redirect_e, imem_ready, dmem_req_m, dmem_ready}
    task automatic step(input logic [7:0] in, input logic [9:0] e, input string t);
        @(negedge clk);
        {reset, b.lu_stall_f, b.lu_stall_d, b.lu_flush_e, b.redirect_e, b.imem_ready, b.dmem_req_m, b.dmem_ready} = in;
        if (reset) begin
            m_stall = '0;
            m_flush = '0;
        end
        exp_q.push_back(e);
        tag_q.push_back(t);
        #2;
        check_out();
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        {b.lu_stall_f, b.lu_stall_d, b.lu_flush_e, b.redirect_e, b.imem_ready, b.dmem_req_m, b.dmem_ready} = 7'b000_0_1_0_0;
        step(8'b1_000_0_1_0_0, RST, "reset");
        step(8'b1_111_1_0_1_0, RST, "reset_busy_inputs");
        step(8'b0_000_0_1_0_0, RUN, "idle");
        step(8'b0_000_0_0_0_0, IMS, "imem_stall");
        step(8'b0_111_0_1_0_0, LU, "loaduse");
        step(8'b0_001_0_1_0_0, 10'b11111_010_0_0, "lu_flush_only");
        step(8'b0_110_0_0_0_0, 10'b00111_000_0_0, "lu_over_imem");
        step(8'b0_111_1_1_0_0, RDR, "redir_lu");
        step(8'b0_000_0_1_1_1, RUN, "mem_hit");
        step(8'b0_000_0_1_1_0, MS, "ms_idle");
        step(8'b0_000_1_1_1_0, MSB, "ms_wait_redir");
        step(8'b0_000_1_1_1_0, MSB, "ms_wait2");
        step(8'b0_000_1_1_1_1, 10'b11111_110_1_0, "release_redir");
        step(8'b0_000_0_1_0_0, RUN, "after_release");
        step(8'b0_000_0_1_1_0, MS, "to_idle");
        for (int i = 1; i <= 4; i++) step(8'b0_000_0_1_1_0, MSB, $sformatf("to_wait%0d", i));
        step(8'b0_000_0_1_1_0, ERR, "to_err");
        step(8'b0_000_1_1_1_1, ERR, "err_absorb_ready");
        step(8'b0_000_0_1_0_0, ERR, "err_absorb_idle");
        step(8'b1_000_0_1_0_0, RST, "rst_in_err");
        step(8'b0_000_0_1_0_0, RUN, "post_err_idle");
        step(8'b0_000_0_1_1_0, MS, "w2_idle");
        step(8'b0_000_0_1_1_0, MSB, "w2_wait");
        step(8'b1_000_0_1_1_0, RST, "rst_mid_wait");
        step(8'b0_000_0_1_0_0, RUN, "post_rst_idle");
        step(8'b0_000_0_1_1_1, RUN, "post_rst_hit");
        step(8'b0_000_0_0_0_0, IMS, "final_imem");
        step(8'b0_000_0_1_0_0, RUN, "final_run");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
